// File: rtl/pulse_stretch.sv
// Stretches a single-cycle strobe into a level of programmable length, then
// holds off for GAP_CYC cycles. Optional retrigger: `define PULSE_STRETCH_RETRIGGER_EN.
module pulse_stretch #(
  parameter int CNT_W   = 16,
  parameter int GAP_CYC = 4,
  parameter int MISS_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              trig,
  input  logic [CNT_W-1:0]  hold_len,
  input  logic              clr_missed,
  output logic              level,
  output logic              busy,
  output logic              done,
  output logic [MISS_W-1:0] missed_cnt
);

`ifdef PULSE_STRETCH_RETRIGGER_EN
  localparam bit RETRIG = 1'b1;
`else
  localparam bit RETRIG = 1'b0;
`endif

  localparam int GAP_W = (GAP_CYC <= 1) ? 1 : $clog2(GAP_CYC);
  localparam logic [GAP_W-1:0] GAP_INIT = GAP_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    GAP
  } state_e;

  state_e              state_q;
  logic [CNT_W-1:0]    hold_q;
  logic [GAP_W-1:0]    gap_q;
  logic                level_q;
  logic                busy_q;
  logic                done_q;
  logic [MISS_W-1:0]   missed_q;

  logic [CNT_W-1:0]    hold_load;
  logic                drop;
  logic [MISS_W-1:0]   missed_d;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned (no latch); blocking '=' is correct here, including the
  // read-after-write of missed_d below.
  always_comb begin
    hold_load = (hold_len == '0) ? '0 : hold_len - CNT_W'(1);
    drop      = trig && (((state_q == HOLD) && !RETRIG) || (state_q == GAP));
    missed_d  = clr_missed ? '0 : missed_q;
    if (drop && (missed_d != '1)) begin
      missed_d = missed_d + MISS_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking '<=' so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      hold_q   <= '0;
      gap_q    <= '0;
      level_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      missed_q <= '0;
    end else begin
      missed_q <= missed_d;
      done_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (trig) begin
            state_q <= HOLD;
            hold_q  <= hold_load;
            level_q <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        HOLD: begin
          // A retrigger on the final hold cycle still wins over the fall.
          if (RETRIG && trig) begin
            hold_q <= hold_load;
          end else if (hold_q == '0) begin
            level_q <= 1'b0;
            done_q  <= 1'b1;
            if (GAP_CYC > 0) begin
              state_q <= GAP;
              gap_q   <= GAP_INIT;
            end else begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end
          end else begin
            hold_q <= hold_q - CNT_W'(1);
          end
        end
        GAP: begin
          if (gap_q == '0) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            gap_q <= gap_q - GAP_W'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          level_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign level      = level_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign missed_cnt = missed_q;

endmodule

// File: tb/tb_pulse_stretch.sv
// Directed plus random bench for pulse_stretch, checked against a timeline model
// (pulse start / level end / busy end edge numbers) built from the behaviour rules.
module tb_pulse_stretch;

  localparam int CNT_W   = 8;
  localparam int GAP_CYC = 2;
  localparam int MISS_W  = 8;
  localparam int MISS_MAX = (1 << MISS_W) - 1;

`ifdef PULSE_STRETCH_RETRIGGER_EN
  localparam bit RETRIG = 1'b1;
`else
  localparam bit RETRIG = 1'b0;
`endif

  logic              clk;
  logic              rst;
  logic              trig;
  logic [CNT_W-1:0]  hold_len;
  logic              clr_missed;
  logic              level;
  logic              busy;
  logic              done;
  logic [MISS_W-1:0] missed_cnt;

  pulse_stretch #(
    .CNT_W  (CNT_W),
    .GAP_CYC(GAP_CYC),
    .MISS_W (MISS_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .trig      (trig),
    .hold_len  (hold_len),
    .clr_missed(clr_missed),
    .level     (level),
    .busy      (busy),
    .done      (done),
    .missed_cnt(missed_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Timeline model: edge index e; pulse accepted at t_start, level high on
  // edges [t_start, t_lend), done on edge t_lend, busy on edges [t_start, t_bend).
  int e = 0;
  bit act = 0;
  int t_start, t_lend, t_bend;
  int m_missed = 0;
  int hi_cnt, busy_cnt, done_cnt;

  task automatic check(input string tag, input int obs, input int expv);
    checks++;
    assert (obs === expv)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d (edge %0d)", tag, obs, expv, e);
    end
  endtask

  task automatic model_edge(input bit t, input int len, input bit c);
    int  lmin;
    bit  in_hold, in_gap, idle, drop;
    lmin    = (len < 1) ? 1 : len;
    in_hold = act && (e > t_start) && (e <= t_lend);
    in_gap  = act && (e > t_lend) && (e <= t_bend);
    idle    = !in_hold && !in_gap;
    drop    = 1'b0;
    if (t) begin
      if (idle) begin
        act     = 1'b1;
        t_start = e;
        t_lend  = e + lmin;
        t_bend  = t_lend + GAP_CYC;
      end else if (in_hold && RETRIG) begin
        t_lend = e + lmin;
        t_bend = t_lend + GAP_CYC;
      end else begin
        drop = 1'b1;
      end
    end
    if (c) m_missed = 0;
    if (drop && m_missed < MISS_MAX) m_missed++;
  endtask

  task automatic step(input bit t, input int len, input bit c);
    bit xl, xb, xd;
    trig       = t;
    hold_len   = len[CNT_W-1:0];
    clr_missed = c;
    @(posedge clk);
    e++;
    model_edge(t, len, c);
    xl = act && (t_start <= e) && (e < t_lend);
    xb = act && (t_start <= e) && (e < t_bend);
    xd = act && (e == t_lend);
    #1;
    check("level", int'(level), int'(xl));
    check("busy", int'(busy), int'(xb));
    check("done", int'(done), int'(xd));
    check("missed_cnt", int'(missed_cnt), m_missed);
    if (level) hi_cnt++;
    if (busy) busy_cnt++;
    if (done) done_cnt++;
  endtask

  task automatic clr_counts();
    hi_cnt   = 0;
    busy_cnt = 0;
    done_cnt = 0;
  endtask

  initial begin
    rst        = 1'b0;
    trig       = 1'b0;
    hold_len   = '0;
    clr_missed = 1'b0;
    #12;
    check("rst_level", int'(level), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_missed", int'(missed_cnt), 0);
    rst = 1'b1;

    // Basic pulse
    clr_counts();
    step(1, 5, 0);
    repeat (8) step(0, 5, 0);
    check("basic_hi", hi_cnt, 5);
    check("basic_busy", busy_cnt, 7);
    check("basic_done", done_cnt, 1);
    check("basic_missed", int'(missed_cnt), 0);

    // Zero length behaves as one
    clr_counts();
    step(1, 0, 0);
    repeat (4) step(0, 0, 0);
    check("zero_hi", hi_cnt, 1);
    check("zero_busy", busy_cnt, 3);
    check("zero_done", done_cnt, 1);

    // Second trig on the third high cycle
    clr_counts();
    step(1, 5, 0);
    step(0, 5, 0);
    step(0, 5, 0);
    step(1, 5, 0);
    repeat (10) step(0, 5, 0);
    check("rehold_hi", hi_cnt, RETRIG ? 8 : 5);
    check("rehold_done", done_cnt, 1);
    check("rehold_missed", int'(missed_cnt), RETRIG ? 0 : 1);

    // Holdoff: drop in 2nd GAP cycle, accept right after busy falls
    clr_counts();
    step(1, 5, 0);
    repeat (6) step(0, 5, 0);
    step(1, 5, 0);
    step(1, 5, 0);
    repeat (8) step(0, 5, 0);
    check("holdoff_hi", hi_cnt, 10);
    check("holdoff_done", done_cnt, 2);
    check("holdoff_missed", int'(missed_cnt), RETRIG ? 1 : 2);

    // Saturation: two GAP drops per four-cycle round, 300 drops total
    for (int i = 0; i < 150; i++) begin
      step(1, 1, 0);
      step(0, 1, 0);
      step(1, 1, 0);
      step(1, 1, 0);
    end
    check("sat_missed", int'(missed_cnt), MISS_MAX);
    step(1, 1, 0);
    step(0, 1, 0);
    step(1, 1, 1);
    check("clr_drop_missed", int'(missed_cnt), 1);
    step(0, 1, 1);
    check("clr_only_missed", int'(missed_cnt), 0);

    // Async reset mid-HOLD, with missed_cnt nonzero beforehand
    step(1, 1, 0);
    step(0, 1, 0);
    step(1, 1, 0);
    step(0, 1, 0);
    step(0, 1, 0);
    step(1, 10, 0);
    repeat (3) step(0, 10, 0);
    check("pre_rst_missed", int'(missed_cnt), 1);
    #3;
    rst = 1'b0;
    #1;
    act      = 1'b0;
    m_missed = 0;
    check("arst_level", int'(level), 0);
    check("arst_busy", int'(busy), 0);
    check("arst_done", int'(done), 0);
    check("arst_missed", int'(missed_cnt), 0);
    #2;
    rst = 1'b1;
    clr_counts();
    repeat (12) step(0, 10, 0);
    check("post_rst_no_done", done_cnt, 0);
    clr_counts();
    step(1, 10, 0);
    repeat (13) step(0, 10, 0);
    check("post_rst_hi", hi_cnt, 10);
    check("post_rst_done", done_cnt, 1);

    // Random traffic against the model
    for (int i = 0; i < 1500; i++) begin
      step($urandom_range(0, 3) == 0, int'($urandom_range(0, 6)),
           $urandom_range(0, 15) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
